// File: rtl/fc_seq_ctrl_pkg.sv
// Shared definitions for the fc sequencer: state encoding and default geometry
// used by the fc engine and the feature buffer.
package fc_seq_ctrl_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_LANES   = 6;
    localparam int DEF_W_BITS  = 192;
    localparam int DEF_N_BEATS = 32;
    localparam int DEF_IV_GAP  = 1;
    localparam int DEF_N_OUT   = 10;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_FEED   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the binarized fc engine: loads weight bits, streams feature beats
// with paced fc_ivalid, collects results and reports done/err.
module fc_seq_ctrl
    import fc_seq_ctrl_pkg::*;
#(
    parameter int   DW      = DEF_DW,
    parameter int   LANES   = DEF_LANES,
    parameter int   W_BITS  = DEF_W_BITS,
    parameter int   N_BEATS = DEF_N_BEATS,
    parameter int   IV_GAP  = DEF_IV_GAP,
    parameter int   N_OUT   = DEF_N_OUT,
    parameter logic W_INV   = 1'b1,
    parameter int   TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   reload_w,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   w_rd_en,
    output logic [7:0]             w_rd_addr,
    input  logic                   w_rd_data,
    output logic                   f_rd_en,
    output logic [4:0]             f_rd_addr,
    input  logic [LANES*DW-1:0]    f_rd_data,
    output logic                   fc_weight_en,
    output logic                   fc_weight,
    output logic                   fc_ivalid,
    output logic signed [DW-1:0]   fc_din_0,
    output logic signed [DW-1:0]   fc_din_1,
    output logic signed [DW-1:0]   fc_din_2,
    output logic signed [DW-1:0]   fc_din_3,
    output logic signed [DW-1:0]   fc_din_4,
    output logic signed [DW-1:0]   fc_din_5,
    input  logic                   fc_ovalid,
    input  logic signed [DW-1:0]   fc_dout,
    output logic                   res_valid,
    output logic [3:0]             res_idx,
    output logic signed [DW-1:0]   res_data,
    output logic [1:0]             dbg_state
);

    localparam logic [8:0]  W_LAST    = 9'(W_BITS);
    localparam logic [4:0]  BEAT_LAST = 5'(N_BEATS - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(IV_GAP);
    localparam logic [3:0]  OUT_N     = 4'(N_OUT);
    localparam logic [3:0]  OUT_LAST  = 4'(N_OUT - 1);
    localparam logic [10:0] TO_LAST   = 11'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          w_loaded;
    logic [8:0]    lcnt;
    logic [4:0]    fa;
    logic [3:0]    ph;
    logic [3:0]    rcnt;
    logic [10:0]   tcnt;
    logic          accept_start, accept_res, all_in, finish, timeout;
    logic [DW-1:0] din_q   [LANES];
    logic [DW-1:0] din_out [LANES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        w_rd_en      = 1'b0;
        f_rd_en      = 1'b0;
        fc_ivalid    = 1'b0;
        accept_start = 1'b0;
        finish       = 1'b0;
        timeout      = 1'b0;
        accept_res   = fc_ovalid && (state_q == ST_FEED || state_q == ST_DRAIN) && (rcnt < OUT_N);
        all_in       = (rcnt == OUT_N) || (accept_res && rcnt == OUT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = (reload_w || !w_loaded) ? ST_LOAD_W : ST_FEED;
                end
            end
            ST_LOAD_W: begin
                w_rd_en = (lcnt < W_LAST);
                if (lcnt == W_LAST) state_d = ST_FEED;
            end
            ST_FEED: begin
                // ph 0 reads a beat, ph 1 presents it; the next read lands on the last gap cycle
                f_rd_en   = (ph == 4'd0);
                fc_ivalid = (ph == 4'd1);
                if (fc_ivalid && fa == BEAT_LAST) begin
                    if (all_in) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (all_in) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tcnt == TO_LAST) begin
                    timeout = 1'b1;
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done         <= 1'b0;
            err          <= 1'b0;
            w_loaded     <= 1'b0;
            fc_weight_en <= 1'b0;
            res_valid    <= 1'b0;
            res_idx      <= '0;
            res_data     <= '0;
            lcnt         <= '0;
            fa           <= '0;
            ph           <= '0;
            rcnt         <= '0;
            tcnt         <= '0;
        end else begin
            done         <= finish;
            fc_weight_en <= w_rd_en;
            res_valid    <= accept_res;
            if (accept_start) begin
                err  <= 1'b0;
                lcnt <= '0;
                fa   <= '0;
                ph   <= '0;
                rcnt <= '0;
                tcnt <= '0;
            end else begin
                if (timeout) err <= 1'b1;
                if (state_q == ST_LOAD_W) begin
                    lcnt <= lcnt + 9'd1;
                    if (lcnt == W_LAST) w_loaded <= 1'b1;
                end
                if (state_q == ST_FEED) begin
                    ph <= (ph == GAP_LAST) ? 4'd0 : ph + 4'd1;
                    if (fc_ivalid) fa <= fa + 5'd1;
                end
                if (state_q == ST_DRAIN) tcnt <= tcnt + 11'd1;
                if (accept_res) begin
                    res_data <= fc_dout;
                    res_idx  <= rcnt;
                    rcnt     <= rcnt + 4'd1;
                end
            end
        end
    end

    // Lanes pass straight through on the ivalid cycle and are held afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) din_q[i] <= '0;
        end else if (fc_ivalid) begin
            for (int i = 0; i < LANES; i++) din_q[i] <= f_rd_data[i*DW +: DW];
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            din_out[i] = fc_ivalid ? f_rd_data[i*DW +: DW] : din_q[i];
        end
    end

    assign fc_din_0  = din_out[0];
    assign fc_din_1  = din_out[1];
    assign fc_din_2  = din_out[2];
    assign fc_din_3  = din_out[3];
    assign fc_din_4  = din_out[4];
    assign fc_din_5  = din_out[5];
    assign fc_weight = fc_weight_en & (w_rd_data ^ W_INV);
    assign w_rd_addr = lcnt[7:0];
    assign f_rd_addr = fa;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Bench for fc_seq_ctrl: buffer and fc responders, an event-level reference
// model, a per-cycle compare process and a final report.
module tb_fc_seq_ctrl;
    import fc_seq_ctrl_pkg::*;

    localparam int DW = 32, LANES = 6, W_BITS = 192, N_BEATS = 32;
    localparam int IV_GAP = 1, N_OUT = 10, TIMEOUT = 1024;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, reload_w = 1'b0;
    logic busy, done, err, w_rd_en, f_rd_en, fc_weight_en, fc_weight, fc_ivalid;
    logic [7:0] w_rd_addr;
    logic [4:0] f_rd_addr;
    logic w_rd_data = 1'b0;
    logic [LANES*DW-1:0] f_rd_data = '0;
    logic signed [DW-1:0] d0, d1, d2, d3, d4, d5;
    logic fc_ovalid = 1'b0;
    logic signed [DW-1:0] fc_dout = '0;
    logic res_valid;
    logic [3:0] res_idx;
    logic signed [DW-1:0] res_data;
    logic [1:0] dbg_state;

    fc_seq_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .reload_w(reload_w),
        .busy(busy), .done(done), .err(err),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .f_rd_en(f_rd_en), .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data),
        .fc_weight_en(fc_weight_en), .fc_weight(fc_weight), .fc_ivalid(fc_ivalid),
        .fc_din_0(d0), .fc_din_1(d1), .fc_din_2(d2), .fc_din_3(d3), .fc_din_4(d4), .fc_din_5(d5),
        .fc_ovalid(fc_ovalid), .fc_dout(fc_dout),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- buffers (1-cycle read latency) ----------------
    logic          wmem [W_BITS];
    logic [DW-1:0] fmem [N_BEATS][LANES];

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (f_rd_en) for (int i = 0; i < LANES; i++) f_rd_data[i*DW +: DW] <= fmem[f_rd_addr][i];
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0, n_fail = 0;
    bit run_active = 0, exp_reload = 0, exp_err = 0, w_loaded_m = 0;
    int start_cyc, wen_cnt, wrd_cnt, iv_cnt, res_cnt, done_seen;
    int last_wen_cyc, last_iv_cyc, first_iv_cyc, last_res_cyc, done_cyc;
    logic done_err;
    logic          exp_w_q   [$];
    logic [DW-1:0] exp_res_q [$];
    logic          cap_w   [4];
    logic [DW-1:0] cap_b5  [LANES];
    logic [DW-1:0] cap_res [N_OUT];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] din_at(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            3: return d3;
            4: return d4;
            default: return d5;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int exp_c;
        if (run_active) begin
            if (w_rd_en) begin
                chk("w_rd_addr", w_rd_addr, wrd_cnt);
                wrd_cnt++;
            end
            if (fc_weight_en) begin
                chk("weight_en_vs_ivalid", fc_ivalid, 0);
                exp_c = (wen_cnt == 0) ? start_cyc + 2 : last_wen_cyc + 1;
                chk("weight_en_cycle", cyc, exp_c);
                if (exp_w_q.size() == 0) chk("weight_en_unexpected", wen_cnt, 0);
                else chk("fc_weight", fc_weight, exp_w_q.pop_front());
                if (wen_cnt < 4) cap_w[wen_cnt] = fc_weight;
                last_wen_cyc = cyc;
                wen_cnt++;
            end
            if (f_rd_en) chk("f_rd_addr", f_rd_addr, iv_cnt);
            if (fc_ivalid) begin
                if (iv_cnt == 0) exp_c = exp_reload ? last_wen_cyc + 2 : start_cyc + 2;
                else exp_c = last_iv_cyc + 1 + IV_GAP;
                chk("ivalid_cycle", cyc, exp_c);
                if (iv_cnt < N_BEATS) begin
                    for (int i = 0; i < LANES; i++) chk("fc_din", din_at(i), fmem[iv_cnt][i]);
                    if (iv_cnt == 5) for (int i = 0; i < LANES; i++) cap_b5[i] = din_at(i);
                end else begin
                    chk("ivalid_extra", iv_cnt, N_BEATS - 1);
                end
                if (iv_cnt == 0) first_iv_cyc = cyc;
                last_iv_cyc = cyc;
                iv_cnt++;
            end
            if (res_valid) begin
                chk("res_idx", res_idx, res_cnt);
                if (exp_res_q.size() == 0) chk("res_unexpected", res_cnt, N_OUT);
                else chk("res_data", res_data, exp_res_q.pop_front());
                if (res_cnt < N_OUT) cap_res[res_cnt] = res_data;
                last_res_cyc = cyc;
                res_cnt++;
            end
            if (done) begin
                chk("busy_at_done", busy, 0);
                done_seen++;
                done_cyc = cyc;
                done_err = err;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic emit(input int n_ov, input int ov_after, input bit seq_dout);
        int k;
        logic [DW-1:0] v;
        k = 0;
        while (iv_cnt < ov_after && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (iv_cnt < ov_after) chk("emit_wait_ivalid", iv_cnt, ov_after);
        for (int p = 0; p < n_ov; p++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            v = seq_dout ? DW'(p) : DW'($urandom);
            if (p < N_OUT) exp_res_q.push_back(v);
            fc_ovalid = 1'b1;
            fc_dout   = v;
            @(negedge clk);
            fc_ovalid = 1'b0;
        end
    endtask

    task automatic run_inf(input bit rl, input int n_ov, input int ov_after,
                           input bit seq_dout, input bit intrude);
        int exp_done, exp_nres;
        exp_reload = rl || !w_loaded_m;
        exp_err    = (n_ov < N_OUT);
        exp_nres   = (n_ov < N_OUT) ? n_ov : N_OUT;
        wen_cnt = 0; wrd_cnt = 0; iv_cnt = 0; res_cnt = 0; done_seen = 0;
        last_wen_cyc = 0; last_iv_cyc = 0; first_iv_cyc = 0; last_res_cyc = 0; done_cyc = 0;
        exp_w_q.delete();
        exp_res_q.delete();
        if (exp_reload) for (int i = 0; i < W_BITS; i++) exp_w_q.push_back(~wmem[i]);
        run_active = 1;
        // a result pulse while idle must be ignored
        @(negedge clk);
        fc_ovalid = 1'b1;
        fc_dout   = DW'($urandom);
        @(negedge clk);
        fc_ovalid = 1'b0;
        start     = 1'b1;
        reload_w  = rl;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        reload_w = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_clear_on_start", err, 0);
        fork
            emit(n_ov, ov_after, seq_dout);
            begin
                if (intrude && exp_reload) begin
                    repeat (20) @(negedge clk);
                    fc_ovalid = 1'b1;
                    start     = 1'b1;
                    reload_w  = 1'b1;
                    @(negedge clk);
                    fc_ovalid = 1'b0;
                    start     = 1'b0;
                    reload_w  = 1'b0;
                end
            end
            begin
                int k;
                k = 0;
                while (done_seen == 0 && k < 4000) begin
                    @(negedge clk);
                    k++;
                end
                if (done_seen == 0) chk("done_wait_expired", done_seen, 1);
            end
        join
        repeat (3) @(negedge clk);
        run_active = 0;
        exp_done = exp_err ? last_iv_cyc + 1 + TIMEOUT
                           : ((last_res_cyc > last_iv_cyc + 1) ? last_res_cyc : last_iv_cyc + 1);
        chk("done_pulses", done_seen, 1);
        chk("done_cycle", done_cyc, exp_done);
        chk("w_rd_count", wrd_cnt, exp_reload ? W_BITS : 0);
        chk("weight_en_count", wen_cnt, exp_reload ? W_BITS : 0);
        chk("ivalid_count", iv_cnt, N_BEATS);
        chk("result_count", res_cnt, exp_nres);
        chk("err_at_done", done_err, exp_err);
        chk("err_held", err, exp_err);
        chk("busy_idle", busy, 0);
        if (exp_reload) w_loaded_m = 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_w_rd_en"}, w_rd_en, 0);
        chk({tag, "_w_rd_addr"}, w_rd_addr, 0);
        chk({tag, "_f_rd_en"}, f_rd_en, 0);
        chk({tag, "_f_rd_addr"}, f_rd_addr, 0);
        chk({tag, "_weight_en"}, fc_weight_en, 0);
        chk({tag, "_weight"}, fc_weight, 0);
        chk({tag, "_ivalid"}, fc_ivalid, 0);
        chk({tag, "_din0"}, d0, 0);
        chk({tag, "_din5"}, d5, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < W_BITS; i++) wmem[i] = 1'($urandom);
        for (int b = 0; b < N_BEATS; b++)
            for (int i = 0; i < LANES; i++) fmem[b][i] = DW'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fill_random();
        wmem[0] = 1'b1; wmem[1] = 1'b0; wmem[2] = 1'b1; wmem[3] = 1'b1;
        fmem[5][0] = -3; fmem[5][1] = 7; fmem[5][2] = 0;
        fmem[5][3] = 1;  fmem[5][4] = -1; fmem[5][5] = 2;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // first inference loads weights; results 0..9; stray start/ovalid during load
        run_inf(1'b0, 10, 20, 1'b1, 1'b1);
        chk("pin_wen_total", wen_cnt, 192);
        chk("pin_w0", cap_w[0], 0);
        chk("pin_w1", cap_w[1], 1);
        chk("pin_w2", cap_w[2], 0);
        chk("pin_w3", cap_w[3], 0);
        chk("pin_b5_l0", cap_b5[0], 32'hFFFF_FFFD);
        chk("pin_b5_l1", cap_b5[1], 7);
        chk("pin_b5_l2", cap_b5[2], 0);
        chk("pin_b5_l3", cap_b5[3], 1);
        chk("pin_b5_l4", cap_b5[4], 32'hFFFF_FFFF);
        chk("pin_b5_l5", cap_b5[5], 2);
        for (int i = 0; i < N_OUT; i++) chk("pin_res_seq", cap_res[i], i);
        chk("pin_done_with_last_res", done_cyc - last_res_cyc, 0);

        // weights already loaded; surplus pulses dropped; results during feed
        run_inf(1'b0, 12, 3, 1'b0, 1'b0);
        chk("pin_first_iv_latency", first_iv_cyc - start_cyc, 2);
        chk("pin_no_wen", wen_cnt, 0);

        // one result short -> timeout
        run_inf(1'b0, 9, 25, 1'b0, 1'b0);
        chk("pin_timeout_gap", done_cyc - last_iv_cyc, 1025);
        chk("pin_timeout_err", done_err, 1);

        // forced reload clears the previous err on start
        fill_random();
        run_inf(1'b1, 11, 30, 1'b0, 1'b0);

        // reset mid-feed, then the next start must reload weights
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        w_loaded_m = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_inf(1'b0, 10, 10, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_inf(1'($urandom_range(0, 1)), $urandom_range(8, 12), $urandom_range(1, 31), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
